// File: rtl/sub_unit.sv
// sub_unit: single-issue 10-bit a-b unit with borrow-lookahead, registered tagged writeback.
// Optional `SUB_UNIT_FLUSH_EN adds a flush input that abandons the in-flight operation.
module sub_unit #(
  parameter int WIDTH   = 10,
  parameter int TAG_W   = 3,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [WIDTH-1:0] res_diff,
  output logic             res_borrow,
  output logic             res_zero
`ifdef SUB_UNIT_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             flush_int;

  logic [WIDTH-1:0] b_inv, gen, prop, diff;
  logic [WIDTH:0]   carry;

`ifdef SUB_UNIT_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  // a - b as a + ~b + 1: carry-in of 1 supplies the two's-complement increment.
  always_comb begin
    b_inv    = ~b_q;
    gen      = a_q & b_inv;
    prop     = a_q ^ b_inv;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    diff = prop ^ carry[WIDTH-1:0];
  end

  always_comb begin
    state_nxt   = state;
    issue_ready = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        issue_ready = 1'b1;
        busy        = 1'b0;
        if (issue_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (flush_int)     state_nxt = IDLE;
        else if (cnt == 0) state_nxt = DONE;
      end
      DONE: begin
        if (flush_int || res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tag_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_valid  <= 1'b0;
      res_tag    <= '0;
      res_diff   <= '0;
      res_borrow <= 1'b0;
      res_zero   <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_valid <= (state_nxt == DONE);
      if (state == IDLE && issue_valid) begin
        tag_q <= issue_tag;
        a_q   <= issue_a;
        b_q   <= issue_b;
        cnt   <= 4'(LATENCY - 1);
      end
      if (state == EXEC && !flush_int && cnt != 0) cnt <= cnt - 4'd1;
      // Result fields only move on EXEC->DONE, so they hold through backpressure and flush.
      if (state == EXEC && state_nxt == DONE) begin
        res_tag    <= tag_q;
        res_diff   <= diff;
        res_borrow <= ~carry[WIDTH];
        res_zero   <= (diff == '0);
      end
    end
  end

endmodule
